riscv_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register. Takes the current PC and issues in-order requests to the instruction memory over a req/gnt + rvalid interface. Buffers returning instructions with their PCs in a small FIFO and presents them to decode. Drives the PC-register stall so the PC advances only when a fetch is accepted, and discards in-flight responses on a pipeline flush.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/riscv_fetch_buffer.sv | 81 ++++++++
 rtl/riscv_fetch.sv | 107 ++++++++++
 tb/tb_riscv_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: NOP encoding, buffer entry layout and default buffer depth.
package riscv_pkg;

    localparam int unsigned FETCH_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        filled;
        logic        misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_buffer.sv
// In-order fetch buffer: entries are allocated at request grant, filled by responses
// in the same order, and popped from the head once filled.
module riscv_fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_alloc,
    input  fetch_entry_t i_alloc_entry,
    input  logic         i_fill,
    input  logic [31:0]  i_fill_instr,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_entries,
    output logic [CW-1:0] o_unfilled
);

    logic [PW-1:0] r_alloc_ptr, r_fill_ptr, r_read_ptr;
    logic [CW-1:0] r_entries, r_unfilled;
    logic          w_fill, w_alloc_pending;
    fetch_entry_t  w_entries [DEPTH];

    // A response with nothing waiting for it is dropped rather than corrupting an entry.
    assign w_fill          = i_fill && (r_unfilled != '0);
    assign w_alloc_pending = i_alloc && !i_alloc_entry.filled;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_read_ptr  <= '0;
            r_entries   <= '0;
            r_unfilled  <= '0;
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_read_ptr  <= '0;
            r_entries   <= '0;
            r_unfilled  <= '0;
        end else begin
            if (i_alloc)  r_alloc_ptr <= r_alloc_ptr + PW'(1);
            if (w_fill)   r_fill_ptr  <= r_fill_ptr + PW'(1);
            if (i_pop)    r_read_ptr  <= r_read_ptr + PW'(1);
            r_entries  <= r_entries + CW'(i_alloc) - CW'(i_pop);
            r_unfilled <= r_unfilled + CW'(w_alloc_pending) - CW'(w_fill);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;
            // Alloc may reuse the slot being popped this cycle, so it takes priority.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_entry <= '0;
                end else if (i_flush) begin
                    r_entry <= '0;
                end else if (i_alloc && (r_alloc_ptr == PW'(gi))) begin
                    r_entry <= i_alloc_entry;
                end else if (w_fill && (r_fill_ptr == PW'(gi))) begin
                    r_entry.instr  <= i_fill_instr;
                    r_entry.filled <= 1'b1;
                end else if (i_pop && (r_read_ptr == PW'(gi))) begin
                    r_entry <= '0;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign o_head     = w_entries[r_read_ptr];
    assign o_entries  = r_entries;
    assign o_unfilled = r_unfilled;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: req/gnt issue, response kill accounting and PC stall.
// Optional misaligned-PC trapping is enabled by defining RISCV_FETCH_MISALIGN_EN.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic        i_riscv_fetch_clk,
    input  logic        i_riscv_fetch_rst,
    input  logic [63:0] i_riscv_fetch_pc,
    output logic        o_riscv_fetch_stallpc,
    output logic        o_riscv_fetch_imem_req,
    output logic [63:0] o_riscv_fetch_imem_addr,
    input  logic        i_riscv_fetch_imem_gnt,
    input  logic        i_riscv_fetch_imem_rvalid,
    input  logic [31:0] i_riscv_fetch_imem_rdata,
    input  logic        i_riscv_fetch_flush,
    input  logic        i_riscv_fetch_stall,
    output logic        o_riscv_fetch_valid,
    output logic [31:0] o_riscv_fetch_instr,
    output logic [63:0] o_riscv_fetch_pc
`ifdef RISCV_FETCH_MISALIGN_EN
    ,
    output logic        o_riscv_fetch_misaligned
`endif
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;

    logic [CW-1:0] w_entries, w_unfilled, r_kill_cnt;
    logic [CW1-1:0] w_occupancy;
    fetch_entry_t  w_head, w_alloc_entry;
    logic w_pop, w_space, w_req, w_issue, w_alloc, w_fill, w_mis_alloc, w_flush_sub;

    assign w_pop       = w_head.filled && !i_riscv_fetch_stall && !i_riscv_fetch_flush;
    // Counting the pop lets a slot freed this cycle be re-requested immediately.
    assign w_occupancy = {1'b0, w_entries} + {1'b0, r_kill_cnt} - CW1'(w_pop);
    assign w_space     = !i_riscv_fetch_rst && !i_riscv_fetch_flush && (w_occupancy < CW1'(DEPTH));

`ifdef RISCV_FETCH_MISALIGN_EN
    logic r_blocked;
    logic w_misaligned_pc;

    assign w_misaligned_pc = (i_riscv_fetch_pc[1:0] != 2'b00);
    assign w_req           = w_space && !w_misaligned_pc && !r_blocked;
    assign w_mis_alloc     = w_space && w_misaligned_pc && !r_blocked;

    always_ff @(posedge i_riscv_fetch_clk or posedge i_riscv_fetch_rst) begin
        if (i_riscv_fetch_rst)        r_blocked <= 1'b0;
        else if (i_riscv_fetch_flush) r_blocked <= 1'b0;
        else if (w_mis_alloc)         r_blocked <= 1'b1;
    end

    assign o_riscv_fetch_misaligned = w_head.misaligned;
`else
    logic w_unused_bits;

    assign w_req         = w_space;
    assign w_mis_alloc   = 1'b0;
    assign w_unused_bits = ^{w_head.misaligned, i_riscv_fetch_pc[1:0]};
`endif

    assign w_issue = w_req && i_riscv_fetch_imem_gnt;
    assign w_alloc = w_issue || w_mis_alloc;
    assign w_fill  = i_riscv_fetch_imem_rvalid && (r_kill_cnt == '0);

    assign w_alloc_entry.pc         = i_riscv_fetch_pc;
    assign w_alloc_entry.instr      = w_mis_alloc ? NOP_INSTR : 32'h0;
    assign w_alloc_entry.filled     = w_mis_alloc;
    assign w_alloc_entry.misaligned = w_mis_alloc;

    // A response in the flush cycle either retires a kill or lands on an entry
    // that is itself being killed; either way it is one fewer response to drop later.
    assign w_flush_sub = i_riscv_fetch_imem_rvalid && ((r_kill_cnt != '0) || (w_unfilled != '0));

    always_ff @(posedge i_riscv_fetch_clk or posedge i_riscv_fetch_rst) begin
        if (i_riscv_fetch_rst)
            r_kill_cnt <= '0;
        else if (i_riscv_fetch_flush)
            r_kill_cnt <= r_kill_cnt + w_unfilled - CW'(w_flush_sub);
        else if (i_riscv_fetch_imem_rvalid && (r_kill_cnt != '0))
            r_kill_cnt <= r_kill_cnt - CW'(1);
    end

    riscv_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .i_clk         (i_riscv_fetch_clk),
        .i_rst         (i_riscv_fetch_rst),
        .i_flush       (i_riscv_fetch_flush),
        .i_alloc       (w_alloc),
        .i_alloc_entry (w_alloc_entry),
        .i_fill        (w_fill),
        .i_fill_instr  (i_riscv_fetch_imem_rdata),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_entries     (w_entries),
        .o_unfilled    (w_unfilled)
    );

    assign o_riscv_fetch_imem_req  = w_req;
    assign o_riscv_fetch_imem_addr = {i_riscv_fetch_pc[63:2], 2'b00};
    assign o_riscv_fetch_stallpc   = i_riscv_fetch_rst || (!w_issue && !i_riscv_fetch_flush);
    assign o_riscv_fetch_valid     = w_head.filled;
    assign o_riscv_fetch_instr     = w_head.instr;
    assign o_riscv_fetch_pc        = w_head.pc;

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboard bench for riscv_fetch: models the PC register and an in-order instruction memory.
module tb_riscv_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pc = 64'h0;
    logic        gnt = 1'b0, rvalid = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        o_stallpc, o_req, o_valid;
    logic [63:0] o_addr, o_pc;
    logic [31:0] o_instr;
`ifdef RISCV_FETCH_MISALIGN_EN
    logic        o_mis;
`endif

    riscv_fetch #(.DEPTH(2)) dut (
        .i_riscv_fetch_clk         (clk),
        .i_riscv_fetch_rst         (rst),
        .i_riscv_fetch_pc          (pc),
        .o_riscv_fetch_stallpc     (o_stallpc),
        .o_riscv_fetch_imem_req    (o_req),
        .o_riscv_fetch_imem_addr   (o_addr),
        .i_riscv_fetch_imem_gnt    (gnt),
        .i_riscv_fetch_imem_rvalid (rvalid),
        .i_riscv_fetch_imem_rdata  (rdata),
        .i_riscv_fetch_flush       (flush),
        .i_riscv_fetch_stall       (stall),
        .o_riscv_fetch_valid       (o_valid),
        .o_riscv_fetch_instr       (o_instr),
        .o_riscv_fetch_pc          (o_pc)
`ifdef RISCV_FETCH_MISALIGN_EN
        ,
        .o_riscv_fetch_misaligned  (o_mis)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

    mreq_t memq[$];
    exp_t  sbq[$];

    int checks = 0, errors = 0, cyc = 0;
    int g_lat = 1;
    bit g_gnt = 1'b1, g_stall = 1'b0, g_flush = 1'b0, g_flush_armed = 1'b0, flush_hit = 1'b0;
    logic [63:0] g_target = 64'h0, prev_target = 64'h0;
    bit prev_flush = 1'b0, prev_stallpc = 1'b1;
    int first_gnt = -1, first_valid = -1, pops = 0;
    logic        s_req, s_stallpc, s_valid, s_pop;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return 32'h0000_0013 ^ {a[17:2], 16'h0000};
    endfunction

    // One clock of the PC register, the memory and the decode consumer.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (prev_flush)         pc = prev_target;
        else if (!prev_stallpc) pc = pc + 64'd4;
        gnt   = g_gnt;
        stall = g_stall;
        flush = g_flush;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_data(memq[0].addr);
        end else begin
            rvalid = 1'b0;
            rdata  = 32'h0;
        end
        #1;
        if (g_flush_armed && o_valid && rvalid && !stall) begin
            flush = 1'b1;
            g_flush_armed = 1'b0;
            flush_hit = 1'b1;
            #1;
        end
        s_req = o_req; s_stallpc = o_stallpc; s_valid = o_valid;
        s_addr = o_addr; s_pc = o_pc; s_instr = o_instr;
        s_pop = o_valid && !stall && !flush;
        if (s_pop) begin
            pops++;
            if (first_valid < 0) first_valid = cyc;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got pc=%h instr=%h expected no instruction", o_pc, o_instr);
            end else begin
                e = sbq.pop_front();
                if (o_pc !== e.pc || o_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_pop: got pc=%h instr=%h expected pc=%h instr=%h",
                             o_pc, o_instr, e.pc, e.instr);
                end else begin
                    $display("pop cyc=%0d pc=%h instr=%h", cyc, o_pc, o_instr);
                end
            end
        end
        if (rvalid) void'(memq.pop_front());
        if (flush) sbq.delete();
        if (o_req && gnt) begin
            memq.push_back('{o_addr, cyc + g_lat});
            sbq.push_back('{pc, mem_data({pc[63:2], 2'b00})});
            if (first_gnt < 0) first_gnt = cyc;
        end
        prev_flush   = flush;
        prev_target  = g_target;
        prev_stallpc = o_stallpc;
    endtask

    task automatic test_reset();
        pc = 64'h8000_0000;
        #1 rst = 1'b1;
        #11;
        checks += 5;
        if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        if (o_instr !== 32'h0)  begin errors++; $display("FAIL reset_instr: got %h expected 0", o_instr); end
        if (o_pc !== 64'h0)     begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
        if (o_req !== 1'b0)     begin errors++; $display("FAIL reset_req: got %b expected 0", o_req); end
        if (o_stallpc !== 1'b1) begin errors++; $display("FAIL reset_stallpc: got %b expected 1", o_stallpc); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int p0;
        g_lat = 1; g_gnt = 1'b1; g_stall = 1'b0;
        step();
        checks += 2;
        if (s_req !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %b expected 1", s_req); end
        if (s_addr !== 64'h8000_0000) begin errors++; $display("FAIL stream_first_addr: got %h expected 80000000", s_addr); end
        repeat (5) step();
        checks++;
        if (first_valid - first_gnt != 2)
            begin errors++; $display("FAIL stream_latency: got %0d expected 2", first_valid - first_gnt); end
        p0 = pops;
        repeat (8) step();
        checks++;
        if (pops - p0 != 8) begin errors++; $display("FAIL stream_throughput: got %0d expected 8", pops - p0); end
    endtask

    task automatic test_stall();
        g_stall = 1'b1;
        repeat (4) step();
        checks += 3;
        if (s_req !== 1'b0)     begin errors++; $display("FAIL stall_req: got %b expected 0", s_req); end
        if (s_stallpc !== 1'b1) begin errors++; $display("FAIL stall_stallpc: got %b expected 1", s_stallpc); end
        if (s_valid !== 1'b1)   begin errors++; $display("FAIL stall_valid: got %b expected 1", s_valid); end
        g_stall = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_flush_outstanding();
        bit found = 1'b0;
        g_lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (memq.size() == 2 && memq[0].due > cyc + 1) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL flush_setup: got no 2-outstanding window expected one"); end
        g_target = 64'h8000_1000;
        g_flush = 1'b1;
        step();
        g_flush = 1'b0;
        checks += 2;
        if (s_req !== 1'b0)     begin errors++; $display("FAIL flush_req: got %b expected 0", s_req); end
        if (s_stallpc !== 1'b0) begin errors++; $display("FAIL flush_stallpc: got %b expected 0", s_stallpc); end
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            step();
            if (s_pop) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== 64'h8000_1000)
            begin errors++; $display("FAIL flush_redirect_pc: got %h expected 80001000", s_pc); end
        repeat (4) step();
    endtask

    task automatic test_gnt_withhold();
        logic [63:0] a0;
        g_lat = 1;
        repeat (4) step();
        g_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) a0 = {pc[63:2], 2'b00};
            checks += 3;
            if (s_req !== 1'b1)     begin errors++; $display("FAIL withhold_req: got %b expected 1", s_req); end
            if (s_addr !== a0)      begin errors++; $display("FAIL withhold_addr: got %h expected %h", s_addr, a0); end
            if (s_stallpc !== 1'b1) begin errors++; $display("FAIL withhold_stallpc: got %b expected 1", s_stallpc); end
        end
        g_gnt = 1'b1;
        step();
        checks++;
        if (s_stallpc !== 1'b0) begin errors++; $display("FAIL gnt_stallpc: got %b expected 0", s_stallpc); end
        step();
        checks++;
        if (s_addr !== a0 + 64'd4) begin errors++; $display("FAIL gnt_advance: got %h expected %h", s_addr, a0 + 64'd4); end
        repeat (3) step();
    endtask

    task automatic test_flush_pop();
        bit found = 1'b0;
        g_lat = 1;
        repeat (4) step();
        g_target = 64'h8000_2000;
        g_flush_armed = 1'b1;
        flush_hit = 1'b0;
        for (int i = 0; i < 10 && !flush_hit; i++) step();
        g_flush_armed = 1'b0;
        checks++;
        if (!flush_hit) begin errors++; $display("FAIL flush_pop_setup: got no valid+rvalid cycle expected one"); end
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_valid: got %b expected 0", o_valid); end
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_pop) found = 1'b1;
        end
        checks++;
        if (!found || s_pc !== 64'h8000_2000)
            begin errors++; $display("FAIL flush_pop_redirect: got %h expected 80002000", s_pc); end
        repeat (3) step();
    endtask

    task automatic test_misalign();
        g_target = 64'h8000_0002;
        g_flush = 1'b1;
`ifdef RISCV_FETCH_MISALIGN_EN
        g_stall = 1'b1;
        step();
        g_flush = 1'b0;
        step();
        checks++;
        if (s_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", s_req); end
        step();
        checks += 5;
        if (s_req !== 1'b0)              begin errors++; $display("FAIL mis_blocked: got %b expected 0", s_req); end
        if (s_valid !== 1'b1)            begin errors++; $display("FAIL mis_valid: got %b expected 1", s_valid); end
        if (s_instr !== 32'h0000_0013)   begin errors++; $display("FAIL mis_instr: got %h expected 00000013", s_instr); end
        if (s_pc !== 64'h8000_0002)      begin errors++; $display("FAIL mis_pc: got %h expected 80000002", s_pc); end
        if (o_mis !== 1'b1)              begin errors++; $display("FAIL mis_flag: got %b expected 1", o_mis); end
        g_target = 64'h8000_3000;
        g_flush = 1'b1;
        step();
        g_flush = 1'b0;
        g_stall = 1'b0;
        repeat (6) step();
        checks++;
        if (o_mis !== 1'b0) begin errors++; $display("FAIL mis_cleared: got %b expected 0", o_mis); end
`else
        step();
        g_flush = 1'b0;
        step();
        checks += 2;
        if (s_req !== 1'b1)          begin errors++; $display("FAIL align_req: got %b expected 1", s_req); end
        if (s_addr !== 64'h8000_0000) begin errors++; $display("FAIL align_addr: got %h expected 80000000", s_addr); end
        repeat (6) step();
`endif
    endtask

    task automatic test_drain();
        g_gnt = 1'b0;
        g_stall = 1'b0;
        repeat (8) step();
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL drain_left: got %0d expected 0", sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_outstanding();
        test_gnt_withhold();
        test_flush_pop();
        test_misalign();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
